spi_arb: RTL and testbench
==========================

# spi_arb

Two-client arbiter that shares the single `SPI_mnrch` SPI master between the A2D interface (client 0) and the inertial interface (client 1). Each client keeps its own `wrt`/`wrt_data`/`done` handshake. The arbiter captures requests, grants the bus round-robin and issues one SPI transaction at a time. A lock mechanism keeps multi-frame sequences atomic, such as the A2D command frame followed by its read frame.

## Interface
Parameters:
- HOLD_MAX, 8: maximum cycles a locked owner may wait before issuing its next request, after which the grant is released.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wrt0 / wrt1  in  1  single-cycle request strobe from client 0 / 1
- wrt_data0 / wrt_data1  in  16  frame to send; sampled on the `wrt` cycle
- lock0 / lock1  in  1  owner keeps the grant after its current transaction; sampled on the `spi_done` cycle
- done0 / done1  out  1  single-cycle completion pulse to the owning client
- rd_data  out  16  `spi_rd_data` passed straight through
- gnt  out  2  one-hot current owner; 00 when no client is granted
- err  out  1  sticky flag for a dropped request
- spi_wrt  out  1  start strobe to `SPI_mnrch`
- spi_wrt_data  out  16  frame to `SPI_mnrch`
- spi_done  in  1  completion pulse from `SPI_mnrch`
- spi_rd_data  in  16  received frame from `SPI_mnrch`

## Operation
- Capture:
  - A `wrtN` pulse sets `pendN` and loads `dataN` with `wrt_dataN`.
  - If `pendN` is already set, or client N is the current owner in ISSUE/BUSY, the pulse is dropped, `dataN` is not overwritten, and `err` is set.
  - `err` is cleared only by reset.
- States:
  - IDLE
    - No pending request: stay in IDLE with `gnt`=00.
    - Exactly one pending request: grant that client and go to ISSUE.
    - Both pending: grant the client that is not `last`.
  - ISSUE (exactly one cycle)
    - `spi_wrt`=1 and `spi_wrt_data`=`data[owner]`.
    - Clear `pend[owner]`, go to BUSY.
  - BUSY
    - Wait for `spi_done`.
    - On that cycle `done[owner]`=1 combinationally and `last` is set to the owner.
    - If `lock[owner]`=1, go to HOLD; otherwise go to IDLE.
  - HOLD
    - Grant is retained and `hold_cnt` counts cycles.
    - When `pend[owner]` is set, go to ISSUE.
    - When `hold_cnt`=HOLD_MAX with no owner request, go to IDLE.
    - The other client's requests keep pending and are not served.
- `spi_wrt_data` holds `data[owner]` in all states; it is 0 when `gnt`=00.
- `rd_data` is always `spi_rd_data`.
- `done0`/`done1` never pulse outside BUSY. A stray `spi_done` in any other state is ignored.
- Simultaneous events:
  - The non-owner's `wrt` in the same cycle as `spi_done` is captured normally.
  - Both `wrt0` and `wrt1` in the same cycle are both captured.
  - In a lock handoff, the owner's `wrt` in the same cycle as `spi_done` is captured, and HOLD exits to ISSUE on the next cycle.

## Timing
- Reset values:
  - state=IDLE, `gnt`=00, `last`=1 (client 0 wins the first tie).
  - `pend`=00, `data`=0, `hold_cnt`=0.
  - `err`=0, `spi_wrt`=0, `spi_wrt_data`=0, `done0`/`done1`=0.
- Latency from an idle bus:
  - `wrtN` sampled at edge k → `pendN` high after k → IDLE→ISSUE at edge k+1 → `spi_wrt` high for exactly one cycle after edge k+1.
- Back-to-back within a lock:
  - Owner `wrt` one cycle after `done` → `spi_wrt` two cycles later.
- `done` latency: 0 cycles after `spi_done`.
- `hold_cnt`:
  - Width is $clog2(HOLD_MAX+1).
  - Cleared on entry to HOLD, increments each HOLD cycle, saturates.
- Reset mid-transaction: all state clears immediately. The SPI master is reset by the same `rst_n`, so no partial frame survives.

## Structure
- `spi_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, ISSUE, BUSY, HOLD}
  - the client index constants CLI_A2D=0 and CLI_INERT=1
- The round-robin pick is small enough to stay inline, so no sub-module is needed.
- The top level instantiates `spi_arb` between the A2D and inertial interfaces and the single `SPI_mnrch`.

## Test plan
- Single request: `wrt0` with 16'h0800; `spi_done` 32 cycles after `spi_wrt` with `spi_rd_data`=16'h0ABC → `spi_wrt` 2 cycles after `wrt0` with data 16'h0800; `done0` on the `spi_done` cycle; `rd_data`=16'h0ABC; `done1` stays 0.
- Tie after reset: `wrt0` and `wrt1` in the same cycle → client 0 is served first, then client 1; `gnt` goes 01→10; the next tie goes to client 0 again (`last`=1).
- Lock sequence: client 0 holds `lock0`=1 on its first `done` and pulses `wrt0` with 16'h0001 one cycle later, while `wrt1` is pending → client 0's second frame issues before client 1; `gnt`=01 continuously through both frames.
- HOLD timeout: client 0 locks then never re-requests; `wrt1` pending → after 8 HOLD cycles the arbiter returns to IDLE and client 1 is granted.
- Overflow: `wrt1` pulsed twice while client 0 is BUSY → `err`=1, client 1 sends its first data word only, and `err` stays set until reset.
- Reset mid-BUSY: assert `rst_n` low → all outputs return to their reset values the same cycle; `done0` and `done1` are not pulsed.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types for the two-client SPI arbiter.
//   arb_state_t : arbiter FSM states
//   CLI_A2D     : client index of the A2D interface
//   CLI_INERT   : client index of the inertial interface
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      HOLD  = 2'd3
   } arb_state_t;

   localparam logic CLI_A2D   = 1'b0;
   localparam logic CLI_INERT = 1'b1;

endpackage

// File: rtl/spi_arb.sv
// spi_arb: shares one SPI_mnrch master between the A2D client (0) and the
// inertial client (1). Requests are captured per client, granted
// round-robin, and issued one transaction at a time. A locked owner keeps
// the grant for up to HOLD_MAX idle cycles so multi-frame sequences stay
// atomic.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   wrt0/1, wrt_data0/1      request strobe and frame per client
//   lock0/1                  keep grant after the current frame (sampled on spi_done)
//   done0/1                  completion pulse to the owning client
//   rd_data                  received frame (pass-through of spi_rd_data)
//   gnt                      one-hot owner, 00 when nobody is granted
//   err                      sticky dropped-request flag
//   spi_wrt, spi_wrt_data    start strobe and frame to SPI_mnrch
//   spi_done, spi_rd_data    completion and received frame from SPI_mnrch
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt0,
   input  logic        wrt1,
   input  logic [15:0] wrt_data0,
   input  logic [15:0] wrt_data1,
   input  logic        lock0,
   input  logic        lock1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] rd_data,
   output logic [1:0]  gnt,
   output logic        err,
   output logic        spi_wrt,
   output logic [15:0] spi_wrt_data,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data
);

   localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
   localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(HOLD_MAX);

   arb_state_t       state, state_nxt;
   logic             owner, owner_nxt;
   logic             last, last_nxt;
   logic [1:0]       pend;
   logic [15:0]      data0, data1;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

   logic             owner_active;
   logic             drop0, drop1, take0, take1;
   logic [1:0]       pend_clr;
   logic             owner_lock;

   // The owner may not queue a new frame while its current one is being
   // issued or is in flight; on the completion cycle itself it may, which
   // is what makes a lock handoff back-to-back.
   assign owner_active = (state == ISSUE) || ((state == BUSY) && !spi_done);

   assign drop0 = wrt0 && (pend[0] || ((owner == CLI_A2D)   && owner_active));
   assign drop1 = wrt1 && (pend[1] || ((owner == CLI_INERT) && owner_active));
   assign take0 = wrt0 && !drop0;
   assign take1 = wrt1 && !drop1;

   assign pend_clr   = (state == ISSUE) ? ((owner == CLI_INERT) ? 2'b10 : 2'b01) : 2'b00;
   assign owner_lock = (owner == CLI_INERT) ? lock1 : lock0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend  <= 2'b00;
         data0 <= '0;
         data1 <= '0;
         err   <= 1'b0;
      end else begin
         pend <= (pend & ~pend_clr) | {take1, take0};
         if (take0) data0 <= wrt_data0;
         if (take1) data1 <= wrt_data1;
         if (drop0 || drop1) err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= CLI_A2D;
         last     <= CLI_INERT;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_nxt     = last;
      hold_cnt_nxt = hold_cnt;
      spi_wrt      = 1'b0;
      done0        = 1'b0;
      done1        = 1'b0;
      unique case (state)
         IDLE: begin
            if (pend == 2'b11) begin
               owner_nxt = ~last;
               state_nxt = ISSUE;
            end else if (pend[0]) begin
               owner_nxt = CLI_A2D;
               state_nxt = ISSUE;
            end else if (pend[1]) begin
               owner_nxt = CLI_INERT;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            spi_wrt   = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: begin
            if (spi_done) begin
               done0    = (owner == CLI_A2D);
               done1    = (owner == CLI_INERT);
               last_nxt = owner;
               if (owner_lock) begin
                  hold_cnt_nxt = '0;
                  state_nxt    = HOLD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         HOLD: begin
            if (pend[owner]) begin
               state_nxt = ISSUE;
            end else if (hold_cnt == HOLD_LIM) begin
               state_nxt = IDLE;
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // In IDLE nobody owns the bus, so the grant and outgoing frame read as zero.
   assign gnt          = (state == IDLE) ? 2'b00 : ((owner == CLI_INERT) ? 2'b10 : 2'b01);
   assign spi_wrt_data = (state == IDLE) ? 16'h0000 : ((owner == CLI_INERT) ? data1 : data0);
   assign rd_data      = spi_rd_data;

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: self-checking bench for spi_arb. A transaction-level model of
// the arbiter (owner / issuing / in-flight / held flags) predicts every
// output each cycle; a bench-side SPI master answers each spi_wrt after a
// fixed or random delay and occasionally sends stray spi_done pulses.
module tb_spi_arb;

   localparam int HOLD_MAX = 8;

   logic        clk, rst_n;
   logic        wrt0, wrt1, lock0, lock1;
   logic [15:0] wrt_data0, wrt_data1;
   logic        done0, done1, err, spi_wrt, spi_done;
   logic [15:0] rd_data, spi_wrt_data, spi_rd_data;
   logic [1:0]  gnt;

   spi_arb #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .wrt0(wrt0), .wrt1(wrt1),
      .wrt_data0(wrt_data0), .wrt_data1(wrt_data1),
      .lock0(lock0), .lock1(lock1),
      .done0(done0), .done1(done1),
      .rd_data(rd_data), .gnt(gnt), .err(err),
      .spi_wrt(spi_wrt), .spi_wrt_data(spi_wrt_data),
      .spi_done(spi_done), .spi_rd_data(spi_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_owner;   // -1 = nobody granted
   bit          m_iss, m_infl, m_held;
   int          m_wait, m_last;
   bit          m_pend[2];
   logic [15:0] m_data[2];
   bit          m_err;

   task automatic model_reset();
      m_owner = -1; m_iss = 0; m_infl = 0; m_held = 0; m_wait = 0; m_last = 1;
      m_pend[0] = 0; m_pend[1] = 0; m_data[0] = '0; m_data[1] = '0; m_err = 0;
   endtask

   task automatic model_update();
      bit          w[2], lk[2], op[2], np[2];
      logic [15:0] wd[2];
      w[0] = wrt0; w[1] = wrt1; lk[0] = lock0; lk[1] = lock1;
      wd[0] = wrt_data0; wd[1] = wrt_data1;
      op[0] = m_pend[0]; op[1] = m_pend[1];
      np[0] = m_pend[0]; np[1] = m_pend[1];
      for (int c = 0; c < 2; c++) begin
         if (w[c]) begin
            if (op[c] || (m_owner == c && (m_iss || (m_infl && !spi_done)))) m_err = 1;
            else begin np[c] = 1; m_data[c] = wd[c]; end
         end
      end
      if (m_owner < 0) begin
         int pick = -1;
         if (op[0] && op[1]) pick = 1 - m_last;
         else if (op[0])     pick = 0;
         else if (op[1])     pick = 1;
         if (pick >= 0) begin m_owner = pick; m_iss = 1; end
      end else if (m_iss) begin
         m_iss = 0; m_infl = 1; np[m_owner] = 0;
      end else if (m_infl) begin
         if (spi_done) begin
            m_infl = 0; m_last = m_owner;
            if (lk[m_owner]) begin m_held = 1; m_wait = 0; end
            else m_owner = -1;
         end
      end else if (m_held) begin
         if (op[m_owner])            begin m_held = 0; m_iss = 1; end
         else if (m_wait == HOLD_MAX) begin m_held = 0; m_owner = -1; end
         else m_wait++;
      end
      m_pend[0] = np[0]; m_pend[1] = np[1];
   endtask

   // ---------------- bench SPI master and observers ----------------
   int          slv_cnt = 0;
   int          slv_delay = 4;     // 0 = random 1..6
   bit          slv_fixed = 0;
   logic [15:0] slv_rd = 16'h0;
   bit          stray_en = 0;
   int          cyc = 0;
   int          obs_wrt_cyc, obs_done_cyc, obs_done1_cnt, exp_done_cli;
   logic [15:0] obs_wrt_data, obs_rd;
   logic [1:0]  q_gnt[$];
   logic [15:0] q_data[$];

   task automatic check_outputs();
      int          eg;
      logic [15:0] ed;
      eg = (m_owner < 0) ? 0 : (1 << m_owner);
      ed = (m_owner < 0) ? 16'h0 : m_data[m_owner];
      chk("gnt",          32'(gnt),          32'(eg));
      chk("spi_wrt",      32'(spi_wrt),      32'(m_iss));
      chk("spi_wrt_data", 32'(spi_wrt_data), 32'(ed));
      chk("done0",        32'(done0),        32'(m_infl && spi_done && m_owner == 0));
      chk("done1",        32'(done1),        32'(m_infl && spi_done && m_owner == 1));
      chk("err",          32'(err),          32'(m_err));
      chk("rd_data",      32'(rd_data),      32'(spi_rd_data));
      exp_done_cli = (m_infl && spi_done) ? m_owner : -1;
      if (spi_wrt) begin
         obs_wrt_cyc = cyc; obs_wrt_data = spi_wrt_data;
         q_gnt.push_back(gnt); q_data.push_back(spi_wrt_data);
      end
      if (done0) begin obs_done_cyc = cyc; obs_rd = rd_data; end
      if (done1) begin obs_done_cyc = cyc; obs_rd = rd_data; obs_done1_cnt++; end
   endtask

   // One clock cycle: called at posedge+1 with request inputs already set.
   task automatic tick();
      bit was_iss;
      if (slv_cnt > 0) begin
         slv_cnt--;
         spi_done = (slv_cnt == 0);
      end else begin
         spi_done = stray_en && ($urandom_range(0, 15) == 0);
      end
      spi_rd_data = slv_fixed ? slv_rd : 16'($urandom);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      was_iss = m_iss;
      model_update();
      if (was_iss) slv_cnt = (slv_delay > 0) ? slv_delay : $urandom_range(1, 6);
      #1;
      wrt0 = 0; wrt1 = 0;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 0; wrt0 = 0; wrt1 = 0; lock0 = 0; lock1 = 0;
      wrt_data0 = '0; wrt_data1 = '0; spi_done = 0; spi_rd_data = '0;
      slv_cnt = 0; model_reset();
      q_gnt.delete(); q_data.delete(); obs_done1_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic run_until_done(input int cli, input string tag);
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (exp_done_cli == cli) found = 1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      do_reset();

      // single request
      slv_delay = 32; slv_fixed = 1; slv_rd = 16'h0ABC;
      wrt0 = 1; wrt_data0 = 16'h0800; c0 = cyc;
      tick();
      repeat (40) tick();
      chk("t1_latency",  32'(obs_wrt_cyc - c0), 32'd2);
      chk("t1_data",     32'(obs_wrt_data), 32'h0800);
      chk("t1_done_lat", 32'(obs_done_cyc - obs_wrt_cyc), 32'd32);
      chk("t1_rd",       32'(obs_rd), 32'h0ABC);
      chk("t1_no_done1", 32'(obs_done1_cnt), 32'd0);

      // tie after reset, then second tie
      do_reset();
      slv_delay = 3; slv_fixed = 0;
      wrt0 = 1; wrt1 = 1; wrt_data0 = 16'h1111; wrt_data1 = 16'h2222;
      tick();
      repeat (20) tick();
      wrt0 = 1; wrt1 = 1; wrt_data0 = 16'h3333; wrt_data1 = 16'h4444;
      tick();
      repeat (20) tick();
      chk("tie_count", 32'(q_gnt.size()), 32'd4);
      chk("tie_first",  32'(q_gnt[0]), 32'h1);
      chk("tie_second", 32'(q_gnt[1]), 32'h2);
      chk("tie_again",  32'(q_gnt[2]), 32'h1);

      // lock sequence with client 1 waiting
      do_reset();
      slv_delay = 4;
      lock0 = 1; wrt0 = 1; wrt1 = 1; wrt_data0 = 16'hA5A5; wrt_data1 = 16'h5A5A;
      run_until_done(0, "lock_first_done");
      lock0 = 0; wrt0 = 1; wrt_data0 = 16'h0001;
      tick();
      repeat (20) tick();
      chk("lock_count", 32'(q_data.size()), 32'd3);
      chk("lock_d0", 32'(q_data[0]), 32'hA5A5);
      chk("lock_d1", 32'(q_data[1]), 32'h0001);
      chk("lock_g1", 32'(q_gnt[1]),  32'h1);
      chk("lock_d2", 32'(q_data[2]), 32'h5A5A);

      // hold timeout
      do_reset();
      lock0 = 1; wrt0 = 1; wrt1 = 1; wrt_data0 = 16'h0F0F; wrt_data1 = 16'hF0F0;
      run_until_done(0, "hold_first_done");
      lock0 = 0; c0 = cyc - 1;
      repeat (25) tick();
      chk("hold_timeout", 32'(obs_wrt_cyc - c0), 32'(HOLD_MAX + 3));
      chk("hold_next",    32'(q_data[1]), 32'hF0F0);

      // overflow of client 1 while client 0 is busy
      do_reset();
      slv_delay = 10;
      wrt0 = 1; wrt_data0 = 16'h1000;
      repeat (3) tick();
      wrt1 = 1; wrt_data1 = 16'hAAAA;
      repeat (2) tick();
      wrt1 = 1; wrt_data1 = 16'hBBBB;
      tick();
      repeat (40) tick();
      chk("ovf_err",  32'(err), 32'd1);
      chk("ovf_data", 32'(q_data[1]), 32'hAAAA);

      // randomized traffic with stray spi_done pulses
      do_reset();
      slv_delay = 0; stray_en = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin wrt0 = 1; wrt_data0 = 16'($urandom); end
         if ($urandom_range(0, 7) == 0) begin wrt1 = 1; wrt_data1 = 16'($urandom); end
         lock0 = ($urandom_range(0, 2) == 0);
         lock1 = ($urandom_range(0, 2) == 0);
         tick();
         if (i == 1500) begin
            do_reset();
            stray_en = 1;
         end
      end
      stray_en = 0; lock0 = 0; lock1 = 0;

      // reset in the middle of BUSY
      do_reset();
      slv_delay = 10;
      wrt1 = 1; wrt_data1 = 16'h3333;
      repeat (4) tick();
      rst_n = 0; spi_done = 1;
      #1;
      chk("rst_gnt",      32'(gnt),          32'd0);
      chk("rst_spi_wrt",  32'(spi_wrt),      32'd0);
      chk("rst_wrt_data", 32'(spi_wrt_data), 32'd0);
      chk("rst_done0",    32'(done0),        32'd0);
      chk("rst_done1",    32'(done1),        32'd0);
      chk("rst_err",      32'(err),          32'd0);
      model_reset(); slv_cnt = 0;
      @(negedge clk);
      spi_done = 0; rst_n = 1;
      @(posedge clk); #1;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
